key_event_scanner: RTL and testbench

- Sequencer and event generator behind key_matrix_rx, on the same clk.
- Samples the rx row index and column statuses every cycle and debounces each key in the matrix.
- Turns debounced press/release transitions into code words and queues them in an event FIFO.
- The FIFO has a valid/ready read port that can feed uart_tx directly.

---
 rtl/key_event_scanner.sv | 134 +++++++++++++
 tb/tb_key_event_scanner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_scanner.sv
// Debounces every key of a scanned matrix, one row per cycle, and queues
// press/release code words in a first-word fall-through event FIFO.
module key_event_scanner #(
    parameter int R     = 16,
    parameter int C     = 8,
    parameter int DB    = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(R)-1:0]     row,
    input  logic [C-1:0]             cols,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic                     ev_press,
    output logic [$clog2(R*C)-1:0]   ev_code,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic                     any_down
);
    localparam int RW = $clog2(R);
    localparam int KW = $clog2(R*C);
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int NK = R * C;
    localparam logic [3:0] CNT_DUE = 4'(DB - 1);

    logic [RW-1:0]          row_q;
    logic [C-1:0]           cols_q;
    logic [NK-1:0]          st_q;
    logic [NK-1:0][3:0]     cnt_q;
    logic [DEPTH-1:0][KW:0] mem_q;
    logic [AW-1:0]          wr_q, rd_q;
    logic [AW:0]            count_q;
    logic                   ovf_q, any_down_q;

    logic [KW-1:0]          base;
    logic                   row_ok;
    logic [C-1:0]           diff, due;
    logic                   found;
    logic [CW-1:0]          cand_col;
    logic [KW-1:0]          commit_key;
    logic                   full, empty, push, stall, pop;
    logic [C-1:0][3:0]      cnt_row_d;

    assign base       = KW'(row_q) * KW'(C);
    assign row_ok     = (32'(row_q) < 32'(R));
    assign commit_key = base + KW'(cand_col);

    always_comb begin
        diff     = '0;
        due      = '0;
        found    = 1'b0;
        cand_col = '0;
        for (int c = 0; c < C; c++) begin
            diff[c] = cols_q[c] ^ st_q[base + KW'(c)];
            due[c]  = diff[c] && (cnt_q[base + KW'(c)] == CNT_DUE);
        end
        // Scan downwards so the lowest due column is the one left selected.
        for (int c = C - 1; c >= 0; c--) begin
            if (due[c]) begin
                found    = 1'b1;
                cand_col = CW'(c);
            end
        end
    end

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = row_ok && found && !full;
    assign stall = row_ok && found && full;
    assign pop   = !empty && ev_ready;

    always_comb begin
        cnt_row_d = '0;
        for (int c = 0; c < C; c++) begin
            if (!diff[c])
                cnt_row_d[c] = 4'd0;
            else if (!due[c])
                cnt_row_d[c] = cnt_q[base + KW'(c)] + 4'd1;
            else if (push && (cand_col == CW'(c)))
                cnt_row_d[c] = 4'd0;
            else
                cnt_row_d[c] = CNT_DUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q      <= '0;
            cols_q     <= '0;
            st_q       <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            any_down_q <= 1'b0;
        end else begin
            row_q  <= row;
            cols_q <= cols;
            if (row_ok) begin
                for (int c = 0; c < C; c++)
                    cnt_q[base + KW'(c)] <= cnt_row_d[c];
            end
            if (push) begin
                st_q[commit_key] <= cols_q[cand_col];
                wr_q             <= wr_q + AW'(1);
            end
            if (pop)
                rd_q <= rd_q + AW'(1);
            if (push && !pop)
                count_q <= count_q + (AW+1)'(1);
            else if (!push && pop)
                count_q <= count_q - (AW+1)'(1);
            // A fresh stall takes priority over a clear in the same cycle.
            if (stall)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
            any_down_q <= |st_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= {cols_q[cand_col], commit_key};
    end

    assign ev_valid            = !empty;
    assign {ev_press, ev_code} = ev_valid ? mem_q[rd_q] : '0;
    assign ovf                 = ovf_q;
    assign any_down            = any_down_q;
endmodule

// File: tb/tb_key_event_scanner.sv
// Directed bench for key_event_scanner: rows are scanned 0..15 every frame,
// popped events are logged and compared with hand-computed sequences.
module tb_key_event_scanner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row;
    logic [7:0] cols;
    logic       ev_valid, ev_ready, ev_press, ovf, ovf_clr, any_down;
    logic [6:0] ev_code;

    logic [7:0] keys [16];
    logic [6:0] log_code  [512];
    logic       log_press [512];
    int         log_cyc   [512];
    int         log_n = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         n0;
    int         exp4 [10] = '{40, 48, 41, 49, 42, 43, 44, 45, 46, 47};
    int         exp5a [4] = '{56, 57, 58, 59};
    int         exp5b [9] = '{64, 72, 65, 66, 67, 68, 69, 70, 71};

    key_event_scanner #(.R(16), .C(8), .DB(4), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .cols(cols),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_press(ev_press),
        .ev_code(ev_code), .ovf(ovf), .ovf_clr(ovf_clr), .any_down(any_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && ev_valid && ev_ready && log_n < 512) begin
            log_code[log_n]  <= ev_code;
            log_press[log_n] <= ev_press;
            log_cyc[log_n]   <= cyc;
            log_n            <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_row(input int r);
        row  = 4'(r);
        cols = keys[r];
        @(posedge clk);
        #1;
    endtask

    task automatic rows(input int a, input int b);
        for (int r = a; r <= b; r++) drive_row(r);
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) rows(0, 15);
    endtask

    initial begin
        rst_n = 1'b0; row = '0; cols = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
        for (int r = 0; r < 16; r++) keys[r] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_press", ev_press, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_any_down", any_down, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single press of key 29 and its latency
        ev_ready = 1'b1;
        n0 = log_n;
        keys[3] = 8'h20;
        frames(3);
        rows(0, 3);
        chk("t1_valid_before", ev_valid, 0);
        drive_row(4);
        chk("t1_valid_after", ev_valid, 1);
        chk("t1_code", ev_code, 29);
        chk("t1_press", ev_press, 1);
        rows(5, 15);
        chk("t1_any_down", any_down, 1);
        chk("t1_count", log_n - n0, 1);

        // release, then glitch (no event), then a clean press
        n0 = log_n;
        keys[3] = 8'h00;
        frames(4);
        chk("t2_rel_count", log_n - n0, 1);
        chk("t2_rel_code", log_code[n0], 29);
        chk("t2_rel_press", log_press[n0], 0);
        chk("t2_any_down0", any_down, 0);
        n0 = log_n;
        keys[3] = 8'h20; frames(3);
        keys[3] = 8'h00; frames(1);
        keys[3] = 8'h20; frames(3);
        chk("t2_glitch_none", log_n - n0, 0);
        frames(1);
        chk("t2_press_count", log_n - n0, 1);
        chk("t2_press_code", log_code[n0], 29);
        chk("t2_press_press", log_press[n0], 1);

        // two keys due together in one row
        n0 = log_n;
        keys[2] = 8'b0100_0010;
        frames(5);
        chk("t3_count", log_n - n0, 2);
        chk("t3_code0", log_code[n0], 17);
        chk("t3_code1", log_code[n0+1], 22);
        chk("t3_gap", log_cyc[n0+1] - log_cyc[n0], 16);

        // ten presses with consumer stalled: overflow, then full drain
        ev_ready = 1'b0;
        n0 = log_n;
        keys[5] = 8'hFF;
        keys[6] = 8'h03;
        frames(9);
        chk("t4_ovf_before", ovf, 0);
        chk("t4_valid", ev_valid, 1);
        chk("t4_head_hold", ev_code, 40);
        frames(1);
        chk("t4_ovf_set", ovf, 1);
        ev_ready = 1'b1;
        frames(3);
        chk("t4_count", log_n - n0, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_code%0d", i), log_code[n0+i], exp4[i]);
            chk($sformatf("t4_press%0d", i), log_press[n0+i], 1);
        end
        chk("t4_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        drive_row(0);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", ovf, 0);

        // push and pop in the same cycle with three entries queued
        ev_ready = 1'b0;
        n0 = log_n;
        keys[7] = 8'h0F;
        frames(6);
        rows(0, 7);
        ev_ready = 1'b1;
        drive_row(8);
        ev_ready = 1'b0;
        chk("t5a_head", ev_code, 57);
        ev_ready = 1'b1;
        drive_row(9);
        drive_row(10);
        chk("t5a_valid2", ev_valid, 1);
        chk("t5a_head2", ev_code, 59);
        drive_row(11);
        chk("t5a_valid3", ev_valid, 0);
        rows(12, 15);
        chk("t5a_count", log_n - n0, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t5a_code%0d", i), log_code[n0+i], exp5a[i]);

        // push refused at full while popping, retried on next row visit
        ev_ready = 1'b0;
        n0 = log_n;
        keys[8] = 8'hFF;
        keys[9] = 8'h01;
        frames(10);
        rows(0, 8);
        ev_ready = 1'b1;
        drive_row(9);
        ev_ready = 1'b0;
        chk("t5b_head", ev_code, 72);
        chk("t5b_ovf", ovf, 1);
        rows(10, 15);
        frames(1);
        ev_ready = 1'b1;
        frames(1);
        chk("t5b_count", log_n - n0, 9);
        for (int i = 0; i < 9; i++)
            chk($sformatf("t5b_code%0d", i), log_code[n0+i], exp5b[i]);
        ovf_clr = 1'b1;
        drive_row(0);
        ovf_clr = 1'b0;
        chk("t5b_ovf_clr", ovf, 0);

        // reset mid-drain with key 29 still held
        ev_ready = 1'b0;
        keys[10] = 8'h01;
        frames(4);
        chk("t6_valid_pre", ev_valid, 1);
        chk("t6_code_pre", ev_code, 80);
        ev_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        chk("t6_valid_rst", ev_valid, 0);
        chk("t6_code_rst", ev_code, 0);
        chk("t6_any_down_rst", any_down, 0);
        for (int r = 0; r < 16; r++) if (r != 3) keys[r] = 8'h00;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = log_n;
        frames(4);
        chk("t6_count", log_n - n0, 1);
        chk("t6_code", log_code[n0], 29);
        chk("t6_press", log_press[n0], 1);
        chk("t6_any_down", any_down, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
